// File: rtl/mix_col_enc_seq.sv
`default_nettype none
// ============================================================================
// Module   : mix_col_enc_seq
// Brief    : Forward AES MixColumns, COLS_PER_CYCLE columns per clock, with
//            valid/ready handshakes and per-state bypass for the final round.
// Revision : 1.0 - initial release
// ============================================================================
module mix_col_enc_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         Clk,
   input  logic         RstN,
   input  logic         InValid,
   output logic         InReady,
   input  logic [127:0] DataIn,
   input  logic         Bypass,
   output logic         OutValid,
   input  logic         OutReady,
   output logic [127:0] DataOut
);

   localparam int       c_numGroups = 4 / COLS_PER_CYCLE;
   localparam int       c_grpW      = 32 * COLS_PER_CYCLE;
   localparam bit [1:0] c_lastCnt   = 2'(c_numGroups - 1);

   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_badColsPerCycle
         $error("mix_col_enc_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic [1:0]          r_cnt;
   logic [127:0]        r_work;
   logic                r_outValid;
   logic [c_grpW-1:0]   w_grpIn;
   logic [c_grpW-1:0]   w_grpOut;
   logic                w_accept;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [31:0] mixColumn(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      a0 = a[31:24];
      a1 = a[23:16];
      a2 = a[15:8];
      a3 = a[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Column group r_cnt occupies a contiguous slice, col0 at the MSB end.
   assign w_grpIn = r_work[127 - c_grpW*r_cnt -: c_grpW];

   generate
      for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_mixCol
         assign w_grpOut[c_grpW-1-32*k -: 32] = mixColumn(w_grpIn[c_grpW-1-32*k -: 32]);
      end
   endgenerate

   // Gated by RstN so nothing is offered upstream while held in reset.
   assign InReady  = RstN && ((r_state == IDLE) || ((r_state == DONE) && OutReady));
   assign w_accept = InValid && InReady;

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         r_state    <= IDLE;
         r_cnt      <= 2'd0;
         r_work     <= '0;
         r_outValid <= 1'b0;
      end else if (w_accept) begin
         r_work     <= DataIn;
         r_cnt      <= 2'd0;
         r_state    <= Bypass ? DONE : BUSY;
         r_outValid <= Bypass;
      end else begin
         case (r_state)
            BUSY: begin
               r_work[127 - c_grpW*r_cnt -: c_grpW] <= w_grpOut;
               if (r_cnt == c_lastCnt) begin
                  r_cnt      <= 2'd0;
                  r_state    <= DONE;
                  r_outValid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            DONE: begin
               if (OutReady) begin
                  r_state    <= IDLE;
                  r_outValid <= 1'b0;
               end
            end
            IDLE: ;
            default: begin
               r_state    <= IDLE;
               r_outValid <= 1'b0;
            end
         endcase
      end
   end

   assign OutValid = r_outValid;
   assign DataOut  = r_work;

endmodule
`default_nettype wire
